// File: rtl/nl_spi_pkg.sv
// nl_spi_pkg: shared SPI frame geometry, FSM encoding and command codes
package nl_spi_pkg;
  localparam int LEN_SPI      = 32;
  localparam int SPI_CODE_LEN = 6;
  localparam int SPI_ADDR_LEN = 10;
  localparam int SPI_DATA_LEN = 16;
  localparam int CODE_LSB = SPI_ADDR_LEN + SPI_DATA_LEN;
  localparam int ADDR_LSB = SPI_DATA_LEN;
  localparam int DATA_LSB = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_CHK  = 2'd2;
  typedef enum logic [SPI_CODE_LEN-1:0] {
    CMD_NOP   = 6'd0,
    CMD_RD    = 6'd3,
    CMD_WR    = 6'd4,
    CMD_STAT  = 6'd6,
    CMD_CFG   = 6'd8,
    CMD_DAC0  = 6'd16,
    CMD_DAC1  = 6'd17,
    CMD_DAC2  = 6'd18,
    CMD_DAC3  = 6'd19
  } cmd_code_e;
  typedef struct packed {
    logic [SPI_CODE_LEN-1:0] code;
    logic [SPI_ADDR_LEN-1:0] addr;
    logic [SPI_DATA_LEN-1:0] data;
  } spi_frame_t;
endpackage

// File: rtl/nl_spi_sync_edge.sv
// nl_spi_sync_edge: 2-flop synchronizer plus edge detect on the synchronized level
module nl_spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clk) begin
    if (rst) {meta, sync, prev} <= {3{RST_VAL}};
    else {meta, sync, prev} <= {din, meta, sync};
  end
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/nl_spi_slave_rx.sv
// nl_spi_slave_rx: SPI slave frame receiver with valid/ready command output and read-back.
// Define NL_SPI_ERR_CNT_EN to add the saturating err_cnt output.
module nl_spi_slave_rx
  import nl_spi_pkg::*;
#(
  parameter int LEN_SPI      = nl_spi_pkg::LEN_SPI,
  parameter int SPI_CODE_LEN = nl_spi_pkg::SPI_CODE_LEN,
  parameter int SPI_ADDR_LEN = nl_spi_pkg::SPI_ADDR_LEN,
  parameter int SPI_DATA_LEN = nl_spi_pkg::SPI_DATA_LEN
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic [SPI_CODE_LEN-1:0] cmd_code,
  output logic [SPI_ADDR_LEN-1:0] cmd_addr,
  output logic [SPI_DATA_LEN-1:0] cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  input  logic [LEN_SPI-1:0]      rsp_data,
  input  logic                    rsp_valid,
  output logic                    frame_err,
`ifdef NL_SPI_ERR_CNT_EN
  output logic                    overrun,
  output logic [7:0]              err_cnt
`else
  output logic                    overrun
`endif
);
  logic sck_s, sck_r, sck_f, cs_s, cs_r, cs_f, mosi_s, mosi_r, mosi_f;
  logic unused;
  logic [1:0] state, settle;
  logic armed, start, in_chk, frame_ok, busy, accept;
  logic [5:0] bit_cnt;
  logic [LEN_SPI-1:0] rx_sr, tx_sr, shadow;
  nl_spi_sync_edge #(.RST_VAL(1'b1)) u_sck (.clk(clk_50M), .rst(rst), .din(sck), .sync(sck_s), .rise(sck_r), .fall(sck_f));
  nl_spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk_50M), .rst(rst), .din(cs_n), .sync(cs_s), .rise(cs_r), .fall(cs_f));
  nl_spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk_50M), .rst(rst), .din(mosi), .sync(mosi_s), .rise(mosi_r), .fall(mosi_f));
  assign unused = ^{sck_s, mosi_r, mosi_f};
  assign start    = (state == ST_IDLE) & cs_f & armed;
  assign in_chk   = state == ST_CHK;
  assign frame_ok = bit_cnt == 6'(LEN_SPI);
  assign busy     = cmd_valid & ~cmd_ready;
  assign accept   = in_chk & frame_ok & ~busy;
  // A cs_n held low across reset must not start a frame: arm only once the flushed synchronizer shows cs_n high.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state   <= ST_IDLE;
      settle  <= 2'd0;
      armed   <= 1'b0;
      bit_cnt <= 6'd0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      shadow  <= '0;
      miso    <= 1'b0;
    end else begin
      settle <= settle == 2'd2 ? settle : settle + 2'd1;
      armed  <= armed | ((settle == 2'd2) & cs_s);
      shadow <= rsp_valid ? rsp_data : start ? '0 : shadow;
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_RX;
          bit_cnt <= 6'd0;
          rx_sr   <= '0;
          tx_sr   <= shadow;
          miso    <= shadow[0];
        end
        ST_RX: if (cs_r) begin
          state <= ST_CHK;
          miso  <= 1'b0;
        end else if (sck_f) begin
          rx_sr   <= {mosi_s, rx_sr[LEN_SPI-1:1]};
          bit_cnt <= bit_cnt == 6'(LEN_SPI + 1) ? bit_cnt : bit_cnt + 6'd1;
        end else if (sck_r) begin
          tx_sr <= tx_sr >> 1;
          miso  <= tx_sr[1];
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= in_chk & ~frame_ok;
      overrun   <= overrun | (in_chk & frame_ok & busy);
      if (accept) begin
        cmd_valid <= 1'b1;
        cmd_code  <= rx_sr[CODE_LSB +: SPI_CODE_LEN];
        cmd_addr  <= rx_sr[ADDR_LSB +: SPI_ADDR_LEN];
        cmd_data  <= rx_sr[DATA_LSB +: SPI_DATA_LEN];
      end else if (cmd_ready) cmd_valid <= 1'b0;
    end
  end
`ifdef NL_SPI_ERR_CNT_EN
  always_ff @(posedge clk_50M) begin
    if (rst) err_cnt <= 8'd0;
    else err_cnt <= err_cnt + {7'd0, in_chk & ~accept & ~&err_cnt};
  end
`endif
endmodule

// File: tb/tb_nl_spi_slave_rx.sv
// tb_nl_spi_slave_rx: randomized SPI frames against a queue-based scoreboard
module tb_nl_spi_slave_rx;
  logic clk_50M = 1'b0, rst = 1'b1, sck = 1'b1, cs_n = 1'b1, mosi = 1'b0;
  logic cmd_ready = 1'b1, rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic miso, cmd_valid, frame_err, overrun;
  logic [5:0] cmd_code;
  logic [9:0] cmd_addr;
  logic [15:0] cmd_data;
`ifdef NL_SPI_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int passed = 0, total = 0, err_exp = 0, err_m = 0, rb_n = 0;
  logic ovr_m = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_fe = 1'b0;
  logic [31:0] shadow_m = 32'd0, prev_f = 32'd0, rb_w = 32'd0, rb_e;
  logic [31:0] exp_q[$], rd_q[$];
  time t_rise = 0;

  always #10 clk_50M = ~clk_50M;

  nl_spi_slave_rx dut (
    .clk_50M(clk_50M), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .frame_err(frame_err),
`ifdef NL_SPI_ERR_CNT_EN
    .overrun(overrun), .err_cnt(err_cnt)
`else
    .overrun(overrun)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // command and frame_err monitor, sampled mid-low-phase of clk
  always begin
    @(negedge clk_50M);
    #5;
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (prev_v && !prev_r) check("cmd_hold", 64'({cmd_valid, cmd_code, cmd_addr, cmd_data}), 64'({1'b1, prev_f}));
      if (cmd_valid && !prev_v) check("cmd_latency", 64'($time - t_rise <= 105), 64'd1);
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL cmd_unexpected: got %h, want no command", {cmd_code, cmd_addr, cmd_data});
        end else check("cmd_fields", 64'({cmd_code, cmd_addr, cmd_data}), 64'(exp_q.pop_front()));
      end
      if (frame_err) begin
        total++;
        if (err_exp > 0) begin
          passed++;
          err_exp--;
        end else $display("FAIL frame_err_unexpected: got 1, want 0");
      end
      if (prev_fe) check("frame_err_pulse", 64'(frame_err), 64'd0);
      prev_v = cmd_valid;
      prev_r = cmd_ready;
      prev_fe = frame_err;
      prev_f = {cmd_code, cmd_addr, cmd_data};
    end
  end

  // miso read-back monitor: master samples miso on each sck falling edge
  always begin
    @(negedge cs_n);
    rb_n = 0;
    rb_w = 32'd0;
    while (cs_n == 1'b0) begin
      @(negedge sck or posedge cs_n);
      if (!cs_n) begin
        if (rb_n < 32) rb_w[rb_n[4:0]] = miso;
        rb_n++;
      end
    end
    if (rd_q.size() == 0) begin
      total++;
      $display("FAIL miso_queue: got frame, want none queued");
    end else begin
      rb_e = rd_q.pop_front();
      if (rb_n == 32) check("miso_word", 64'(rb_w), 64'(rb_e));
    end
  end

  task automatic spi_bits(input logic [63:0] f, input int nbits, input int rsp_at, input logic [31:0] rsp_w);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[i];
      if (i == rsp_at) begin
        rsp_data = rsp_w;
        rsp_valid = 1'b1;
        #20;
        rsp_valid = 1'b0;
        shadow_m = rsp_w;
        #80;
      end else #100;
      sck = 1'b0;
      #100;
      sck = 1'b1;
    end
  endtask

  task automatic pulse_rsp(input logic [31:0] w);
    rsp_data = w;
    rsp_valid = 1'b1;
    #20;
    rsp_valid = 1'b0;
    shadow_m = w;
    #20;
  endtask

  task automatic send_frame(input logic [5:0] c, input logic [9:0] a, input logic [15:0] d, input int nbits, input int rsp_at, input logic [31:0] rsp_w);
    logic [63:0] f;
    f = {$urandom, 32'(c) * 32'h0400_0000 + 32'(a) * 32'h0001_0000 + 32'(d)};
    rd_q.push_back(shadow_m);
    shadow_m = 32'd0;
    cs_n = 1'b0;
    #200;
    spi_bits(f, nbits, rsp_at, rsp_w);
    #200;
    if (nbits != 32) begin
      err_exp++;
      err_m++;
    end else if (exp_q.size() != 0) begin
      ovr_m = 1'b1;
      err_m++;
    end else exp_q.push_back({c, a, d});
    t_rise = $time;
    cs_n = 1'b1;
    #400;
    check("overrun", 64'(overrun), 64'(ovr_m));
`ifdef NL_SPI_ERR_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(err_m > 255 ? 255 : err_m));
`endif
  endtask

  task automatic rst_frame();
    rd_q.push_back(shadow_m);
    shadow_m = 32'd0;
    cs_n = 1'b0;
    #200;
    spi_bits({$urandom, $urandom}, 15, -1, 32'd0);
    rst = 1'b1;
    #40;
    rst = 1'b0;
    ovr_m = 1'b0;
    err_m = 0;
    spi_bits({$urandom, $urandom}, 5, -1, 32'd0);
    #200;
    cs_n = 1'b1;
    #400;
    check("rst_no_valid", 64'(cmd_valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
  endtask

  initial begin
    int codes[9] = '{0, 3, 4, 6, 8, 16, 17, 18, 19};
    int odd[5] = '{1, 20, 31, 33, 34};
    logic [5:0] c;
    int nb;
    repeat (5) @(negedge clk_50M);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_fields", 64'({cmd_code, cmd_addr, cmd_data}), 64'd0);
`ifdef NL_SPI_ERR_CNT_EN
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    rst = 1'b0;
    repeat (5) @(negedge clk_50M);
    send_frame(6'd8, 10'd4, 16'h0000, 32, -1, 32'd0);
    pulse_rsp(32'h0000_0001);
    send_frame(6'd3, 10'($urandom), 16'($urandom), 32, -1, 32'd0);
    send_frame(6'd6, 10'($urandom), 16'($urandom), 32, -1, 32'd0);
    cmd_ready = 1'b0;
    send_frame(6'd4, {8'd2, 2'd1}, 16'h003A, 32, -1, 32'd0);
    check("stall_valid", 64'(cmd_valid), 64'd1);
    repeat (20) @(negedge clk_50M);
    cmd_ready = 1'b1;
    repeat (5) @(negedge clk_50M);
    send_frame(6'd17, 10'($urandom), 16'($urandom), 20, -1, 32'd0);
    send_frame(6'd18, 10'($urandom), 16'($urandom), 31, -1, 32'd0);
    send_frame(6'd19, 10'($urandom), 16'($urandom), 33, 12, $urandom);
    cmd_ready = 1'b0;
    send_frame(6'd16, 10'h155, 16'hBEEF, 32, -1, 32'd0);
    send_frame(6'd0, 10'h2AA, 16'h1234, 32, -1, 32'd0);
    check("ovr_keep", 64'({cmd_valid, cmd_code, cmd_addr, cmd_data}), 64'({1'b1, 6'd16, 10'h155, 16'hBEEF}));
    cmd_ready = 1'b1;
    #100;
    send_frame(6'd8, 10'($urandom), 16'($urandom), 32, -1, 32'd0);
    rst_frame();
    send_frame(6'd16, 10'h3FF, 16'hFFFF, 32, -1, 32'd0);
    for (int k = 0; k < 12; k++) begin
      c = 6'(codes[$urandom_range(0, 8)]);
      nb = $urandom_range(0, 3) == 0 ? odd[$urandom_range(0, 4)] : 32;
      if ($urandom_range(0, 2) == 0) pulse_rsp($urandom);
      send_frame(c, 10'($urandom), 16'($urandom), nb, $urandom_range(0, 1) == 0 ? $urandom_range(0, nb - 1) : -1, $urandom);
    end
    #1000;
    check("cmd_queue_drained", 64'(exp_q.size()), 64'd0);
    check("frame_err_drained", 64'(err_exp), 64'd0);
    check("miso_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
